// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding a single 8N1 UART serializer. Bit timing comes
// entirely from the external txclk_en strobe; tx is a registered output.
module uart_tx_scheduler #(
    parameter int NUM_REQ = 2
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 txclk_en,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [1:0]           grant_id
);

    typedef enum logic [1:0] {IDLE, WAIT_START, DATA, STOP} state_e;

    state_e      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        tx_q,    tx_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  ptr_q,   ptr_d;

    logic        win_found;
    logic [1:0]  win_idx;
    logic [7:0]  win_data;

    // Scan from the requester after the last winner, wrapping at NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!win_found && req_valid[j] && (j == (int'(ptr_q) + i) % NUM_REQ)) begin
                    win_found = 1'b1;
                    win_idx   = 2'(j);
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win_idx == 2'(j)) win_data = req_data[8*j +: 8];
        end
    end

    // Gated by rst_n so the handshake is dead while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == IDLE && win_found) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (win_idx == 2'(j)) req_ready[j] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (win_found) begin
                    shift_d = win_data;
                    grant_d = win_idx;
                    ptr_d   = win_idx;
                    state_d = WAIT_START;
                end
            end
            WAIT_START: begin
                if (txclk_en) begin
                    tx_d    = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (txclk_en) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) state_d = STOP;
                end
            end
            STOP: begin
                // cnt 8: stop bit not yet on the line; cnt 9: stop bit has run its period.
                if (txclk_en) begin
                    if (cnt_q == 4'd8) begin
                        tx_d  = 1'b1;
                        cnt_d = 4'd9;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            grant_q <= '0;
            ptr_q   <= 2'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: reset, single byte, contention,
// strobe alignment, withdrawn request and asynchronous abort.
module tb_uart_tx_scheduler;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic        txclk_en;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        tx;
    logic        busy;
    logic [1:0]  grant_id;

    int passed = 0;
    int total  = 0;
    int per    = 4;
    int en_cnt = 0;
    int drop_bit = -1;
    bit strobe_on   = 1'b0;
    bit multi_ready = 1'b0;
    bit ready_seen  = 1'b0;

    uart_tx_scheduler #(.NUM_REQ(2)) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .txclk_en (txclk_en),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .tx       (tx),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #10 clk_50m = ~clk_50m;

    initial begin
        #2ms;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; sample 1 ns after the edge, then schedule the strobe for the next edge.
    task automatic tick();
        @(posedge clk_50m);
        #1;
        if (strobe_on) begin
            en_cnt   = (en_cnt + 1) % per;
            txclk_en = (en_cnt == 0);
        end
        if ($countones(req_ready) > 1) multi_ready = 1'b1;
        if (req_ready != 2'b00) ready_seen = 1'b1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_start(input string tag, input int limit);
        for (int n = 0; n < limit && tx !== 1'b0; n++) tick();
        chk({tag, "_start"}, 32'(tx), 32'd0);
    endtask

    // Called on the first cycle of the start bit; returns on the first IDLE cycle.
    task automatic check_frame(input string tag, input logic [7:0] data, input logic [1:0] gid);
        logic [9:0] frame;
        logic       obs;
        bit         stable;
        frame = {1'b1, data, 1'b0};
        chk({tag, "_grant"}, 32'(grant_id), 32'(gid));
        for (int b = 0; b < 10; b++) begin
            if (b == drop_bit) req_valid = '0;
            obs = tx;
            stable = 1'b1;
            for (int c = 1; c < per; c++) begin
                tick();
                if (tx !== obs) stable = 1'b0;
            end
            chk($sformatf("%s_bit%0d", tag, b), 32'(obs), 32'(frame[b]));
            chk($sformatf("%s_hold%0d", tag, b), 32'(stable), 32'd1);
            tick();
        end
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_tx"}, 32'(tx), 32'd1);
    endtask

    initial begin
        bit tx_low_seen;
        bit busy_seen;
        rst_n     = 1'b0;
        txclk_en  = 1'b0;
        req_valid = '0;
        req_data  = 16'hA55A;

        // 1: outputs pinned while reset is held, whatever the inputs do
        for (int i = 0; i < 6; i++) begin
            req_valid = 2'(i);
            txclk_en  = i[0];
            tick();
            chk($sformatf("rst_tx%0d", i),    32'(tx),        32'd1);
            chk($sformatf("rst_busy%0d", i),  32'(busy),      32'd0);
            chk($sformatf("rst_ready%0d", i), 32'(req_ready), 32'd0);
            chk($sformatf("rst_grant%0d", i), 32'(grant_id),  32'd0);
        end
        req_valid = '0;
        txclk_en  = 1'b0;
        rst_n     = 1'b1;
        tick();
        en_cnt    = 0;
        strobe_on = 1'b1;

        // 2: single byte 0x55 from requester 0
        req_data  = 16'h0055;
        req_valid = 2'b01;
        #1;
        chk("t2_ready", 32'(req_ready), 32'h1);
        tick();
        chk("t2_ready_gone", 32'(req_ready), 32'h0);
        chk("t2_busy", 32'(busy), 32'd1);
        req_valid = '0;
        wait_start("t2", 20);
        check_frame("t2", 8'h55, 2'd0);

        // 3: both requesters held high -> strict alternation
        do_reset();
        multi_ready = 1'b0;
        req_data  = {8'h3C, 8'hA5};
        req_valid = 2'b11;
        #1;
        chk("t3_ready_first", 32'(req_ready), 32'h1);
        for (int k = 0; k < 4; k++) begin
            tick();
            wait_start($sformatf("t3_f%0d", k), 20);
            check_frame($sformatf("t3_f%0d", k), (k % 2 == 0) ? 8'hA5 : 8'h3C, 2'(k % 2));
            if (k < 3) chk($sformatf("t3_ready_next%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h1);
            else req_valid = '0;
        end
        chk("t3_onehot", 32'(multi_ready), 32'd0);

        // 4: strobe on the acceptance edge must not launch the start bit
        do_reset();
        for (int n = 0; n < 8 && txclk_en !== 1'b1; n++) tick();
        req_data  = 16'h0096;
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_no_start", 32'(tx), 32'd1);
        tick(); tick(); tick();
        chk("t4_still_idle_line", 32'(tx), 32'd1);
        tick();
        chk("t4_start_next_strobe", 32'(tx), 32'd0);
        check_frame("t4", 8'h96, 2'd0);

        // 6: requester 0 appears mid-frame and withdraws before IDLE
        do_reset();
        req_data  = {8'h81, 8'h77};
        req_valid = 2'b10;
        #1;
        chk("t6_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid  = 2'b01;
        ready_seen = 1'b0;
        #1;
        chk("t6_no_ready_busy", 32'(req_ready), 32'h0);
        drop_bit = 5;
        wait_start("t6", 20);
        check_frame("t6", 8'h81, 2'd1);
        drop_bit = -1;
        chk("t6_no_ready_pulse", 32'(ready_seen), 32'd0);
        tx_low_seen = 1'b0;
        busy_seen   = 1'b0;
        for (int n = 0; n < 3 * per; n++) begin
            tick();
            if (tx !== 1'b1) tx_low_seen = 1'b1;
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        chk("t6_no_extra_frame", 32'(tx_low_seen), 32'd0);
        chk("t6_stays_idle", 32'(busy_seen), 32'd0);

        // 5: real baud period, async abort during the fourth data bit of 0xF0
        per    = 435;
        en_cnt = 0;
        do_reset();
        req_data  = {8'hF0, 8'h00};
        req_valid = 2'b10;
        #1;
        chk("t5_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        wait_start("t5", 1000);
        for (int n = 0; n < 4 * per; n++) tick();
        chk("t5_bit3_low", 32'(tx), 32'd0);
        chk("t5_grant_pre", 32'(grant_id), 32'd1);
        for (int n = 0; n < 100; n++) tick();
        req_valid = 2'b01;
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_abort_tx", 32'(tx), 32'd1);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_ready", 32'(req_ready), 32'h0);
        chk("t5_abort_grant", 32'(grant_id), 32'd0);
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        req_data  = {8'h0F, 8'h00};
        req_valid = 2'b10;
        #1;
        chk("t5_ready_after", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        wait_start("t5b", 1000);
        check_frame("t5b", 8'h0F, 2'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
